branch_predictor: RTL and testbench

//  Fetch-stage branch predictor: direct-mapped BTB with 2-bit saturating counters.

---
 rtl/branch_predictor_pkg.sv | 21 ++
 rtl/branch_predictor_sat_counter.sv | 17 +
 rtl/branch_predictor.sv | 81 ++++++++
 tb/tb_branch_predictor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared types and constants for the fetch-stage branch predictor
package branch_predictor_pkg;

  typedef logic [31:0] word_t;

  // Tag is stored zero-extended to the widest possible tag (pc[31:2]).
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    word_t       target;
    logic [1:0]  cnt;
  } btb_entry_t;

  localparam logic [1:0] CNT_WEAK_NT = 2'b01;
  localparam logic [1:0] CNT_WEAK_T  = 2'b10;

  function automatic word_t pc_plus4(word_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// rtl/branch_predictor_sat_counter.sv - 2-bit saturating counter next-state logic
module bp_sat_counter (
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != 2'b11) cnt_next = cnt + 2'd1;
    end else begin
      if (cnt != 2'b00) cnt_next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters, mispredict detect and stats
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int BTB_ENTRIES = 16,
  parameter int STAT_W      = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       fetch_pc,
  output logic              predict_taken,
  output logic [31:0]       predict_target,
  input  logic              ex_branch,
  input  logic              ex_en,
  input  logic              halt,
  input  logic [31:0]       ex_pc,
  input  logic              ex_taken,
  input  logic [31:0]       ex_target,
  input  logic              ex_pred_taken,
  input  logic [31:0]       ex_pred_target,
  output logic              mispredict,
  output logic [31:0]       correct_pc,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX = $clog2(BTB_ENTRIES);

  btb_entry_t btb [BTB_ENTRIES];

  logic [IDX-1:0] f_idx, e_idx;
  logic [29:0]    f_tag, e_tag;
  logic           f_hit, e_hit, commit;
  logic [1:0]     cnt_next;

  assign f_idx = fetch_pc[IDX+1:2];
  assign e_idx = ex_pc[IDX+1:2];
  assign f_tag = 30'(fetch_pc[31:IDX+2]);
  assign e_tag = 30'(ex_pc[31:IDX+2]);

  assign f_hit = btb[f_idx].valid && (btb[f_idx].tag == f_tag);
  assign e_hit = btb[e_idx].valid && (btb[e_idx].tag == e_tag);

  // Lookup reads the registered table only, so a same-cycle update is not bypassed.
  assign predict_taken  = f_hit && btb[f_idx].cnt[1];
  assign predict_target = f_hit ? btb[f_idx].target : pc_plus4(fetch_pc);

  assign mispredict = ex_branch &&
                      ((ex_taken != ex_pred_taken) ||
                       (ex_taken && (ex_target != ex_pred_target)));
  assign correct_pc = ex_taken ? ex_target : pc_plus4(ex_pc);

  assign commit = ex_branch && ex_en && !halt;

  bp_sat_counter u_cnt (
    .cnt      (btb[e_idx].cnt),
    .taken    (ex_taken),
    .cnt_next (cnt_next)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_WEAK_NT};
      end
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (commit) begin
      if (e_hit) begin
        btb[e_idx].cnt <= cnt_next;
        if (ex_taken) btb[e_idx].target <= ex_target;
      end else if (ex_taken) begin
        btb[e_idx] <= '{valid: 1'b1, tag: e_tag, target: ex_target, cnt: CNT_WEAK_T};
      end
      if (stat_branches != '1) stat_branches <= stat_branches + 1'b1;
      if (mispredict && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed and randomized self-checking bench for branch_predictor
module tb_branch_predictor;

  localparam int ENTRIES  = 16;
  localparam int SW       = 4;
  localparam int STAT_MAX = (1 << SW) - 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic [31:0]   fetch_pc;
  logic          predict_taken;
  logic [31:0]   predict_target;
  logic          ex_branch, ex_en, halt, ex_taken, ex_pred_taken;
  logic [31:0]   ex_pc, ex_target, ex_pred_target;
  logic          mispredict;
  logic [31:0]   correct_pc;
  logic [SW-1:0] stat_branches, stat_mispredicts;

  int passed = 0;
  int total  = 0;

  // Reference model: entries indexed by word address modulo table size,
  // tag kept as the PC divided by the span one table covers.
  bit          m_valid  [ENTRIES];
  logic [31:0] m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_cnt    [ENTRIES];
  int          m_br, m_mp;

  branch_predictor #(.BTB_ENTRIES(ENTRIES), .STAT_W(SW)) dut (
    .CLK(CLK), .RST(RST), .fetch_pc(fetch_pc),
    .predict_taken(predict_taken), .predict_target(predict_target),
    .ex_branch(ex_branch), .ex_en(ex_en), .halt(halt), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .correct_pc(correct_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 CLK = ~CLK;

  function automatic int m_index(logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    return m_valid[m_index(pc)] && (m_tag[m_index(pc)] == pc / (4 * ENTRIES));
  endfunction

  function automatic bit m_mispredict();
    if (!ex_branch) return 1'b0;
    if (ex_taken != ex_pred_taken) return 1'b1;
    return ex_taken && (ex_target != ex_pred_target);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_cnt[i] = 1;
    end
    m_br = 0; m_mp = 0;
  endtask

  task automatic m_commit();
    int i;
    if (RST) begin
      m_reset();
      return;
    end
    if (!(ex_branch && ex_en && !halt)) return;
    i = m_index(ex_pc);
    if (m_hit(ex_pc)) begin
      m_cnt[i] = ex_taken ? ((m_cnt[i] == 3) ? 3 : m_cnt[i] + 1)
                          : ((m_cnt[i] == 0) ? 0 : m_cnt[i] - 1);
      if (ex_taken) m_target[i] = ex_target;
    end else if (ex_taken) begin
      m_valid[i] = 1; m_tag[i] = ex_pc / (4 * ENTRIES);
      m_target[i] = ex_target; m_cnt[i] = 2;
    end
    if (m_br < STAT_MAX) m_br++;
    if (m_mispredict() && m_mp < STAT_MAX) m_mp++;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_model(string name);
    logic [31:0] exp_tgt;
    bit exp_tk;
    exp_tk  = m_hit(fetch_pc) && (m_cnt[m_index(fetch_pc)] >= 2);
    exp_tgt = m_hit(fetch_pc) ? m_target[m_index(fetch_pc)] : fetch_pc + 32'd4;
    check({name, ".predict_taken"},  32'(predict_taken), 32'(exp_tk));
    check({name, ".predict_target"}, predict_target, exp_tgt);
    check({name, ".mispredict"},     32'(mispredict), 32'(m_mispredict()));
    check({name, ".correct_pc"},     correct_pc, ex_taken ? ex_target : ex_pc + 32'd4);
    check({name, ".stat_branches"},  32'(stat_branches), 32'(m_br));
    check({name, ".stat_mispred"},   32'(stat_mispredicts), 32'(m_mp));
  endtask

  // Inputs are stable from just after a rising edge; compare mid-cycle, then clock.
  task automatic cyc(string name);
    #3;
    check_model(name);
    m_commit();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_ex(logic br, logic en, logic [31:0] pc, logic tk, logic [31:0] tg,
                        logic ptk, logic [31:0] ptg);
    ex_branch = br; ex_en = en; ex_pc = pc; ex_taken = tk;
    ex_target = tg; ex_pred_taken = ptk; ex_pred_target = ptg;
  endtask

  initial begin
    logic [31:0] pool [8];
    RST = 1'b1; halt = 1'b0; fetch_pc = 32'h40;
    set_ex(0, 0, 0, 0, 0, 0, 0);
    m_reset();
    @(posedge CLK); #1;
    cyc("reset_hold");
    RST = 1'b0;

    // 1. reset state
    #3;
    check("t1.predict_taken",  32'(predict_taken), 0);
    check("t1.predict_target", predict_target, 32'h44);
    check("t1.stat_branches",  32'(stat_branches), 0);
    cyc("t1");

    // 2. first taken commit allocates
    set_ex(1, 1, 32'h40, 1, 32'h100, 0, 32'h44);
    #3;
    check("t2.mispredict", 32'(mispredict), 1);
    check("t2.correct_pc", correct_pc, 32'h100);
    cyc("t2");
    set_ex(0, 0, 0, 0, 0, 0, 0);
    #3;
    check("t2.after_taken",  32'(predict_taken), 1);
    check("t2.after_target", predict_target, 32'h100);
    cyc("t2b");

    // 3. two correctly predicted not-taken commits
    set_ex(1, 1, 32'h40, 0, 32'h100, 0, 32'h100);
    cyc("t3a");
    cyc("t3b");
    set_ex(0, 0, 0, 0, 0, 0, 0);
    #3;
    check("t3.predict_taken", 32'(predict_taken), 0);
    check("t3.stat_mispred",  32'(stat_mispredicts), 1);
    cyc("t3c");

    // 4. right direction, wrong target
    set_ex(1, 1, 32'h40, 1, 32'h200, 1, 32'h100);
    #3;
    check("t4.mispredict", 32'(mispredict), 1);
    check("t4.correct_pc", correct_pc, 32'h200);
    cyc("t4");
    set_ex(0, 0, 0, 0, 0, 0, 0);
    #3;
    check("t4.new_target", predict_target, 32'h200);
    cyc("t4b");

    // 5. long stall gives one update
    set_ex(1, 0, 32'h40, 1, 32'h200, 1, 32'h200);
    for (int i = 0; i < 5; i++) cyc("t5.stall");
    ex_en = 1'b1;
    cyc("t5.go");
    set_ex(0, 0, 0, 0, 0, 0, 0);
    #3;
    check("t5.stat_branches", 32'(stat_branches), 5);
    check("t5.predict_taken", 32'(predict_taken), 1);
    cyc("t5b");

    // 6. aliasing eviction, no bypass, halt and reset priority
    fetch_pc = 32'h440;
    set_ex(1, 1, 32'h440, 1, 32'h800, 0, 32'h444);
    #3;
    check("t6.same_cycle_old", predict_target, 32'h444);
    cyc("t6a");
    set_ex(0, 0, 0, 0, 0, 0, 0);
    #3;
    check("t6.new_visible", predict_target, 32'h800);
    fetch_pc = 32'h40;
    #1;
    check("t6.evicted", predict_target, 32'h44);
    cyc("t6b");
    halt = 1'b1;
    set_ex(1, 1, 32'h80, 1, 32'h300, 0, 32'h84);
    cyc("t6.halt");
    halt = 1'b0; ex_branch = 1'b0; fetch_pc = 32'h80;
    #3;
    check("t6.halt_blocked", predict_target, 32'h84);
    cyc("t6c");
    fetch_pc = 32'h440; RST = 1'b1;
    set_ex(1, 1, 32'h440, 1, 32'h900, 1, 32'h800);
    cyc("t6.rst_commit");
    RST = 1'b0; ex_branch = 1'b0;
    #3;
    check("t6.rst_cleared", predict_target, 32'h444);
    cyc("t6d");

    // PC wrap
    fetch_pc = 32'hFFFF_FFFC;
    set_ex(1, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0);
    #3;
    check("wrap.predict_target", predict_target, 32'h0);
    check("wrap.correct_pc", correct_pc, 32'h0);
    cyc("wrap");

    // Randomized phase over a small aliasing PC pool
    for (int i = 0; i < 8; i++)
      pool[i] = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2);
    pool[7] = 32'hFFFF_FFC0;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pc;
      pc       = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      fetch_pc = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      RST      = ($urandom_range(0, 99) == 0);
      halt     = ($urandom_range(0, 15) == 0);
      set_ex($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, pc,
             1'($urandom_range(0, 1)), 32'($urandom_range(0, 3) * 32'h100),
             1'($urandom_range(0, 1)), 32'($urandom_range(0, 3) * 32'h100));
      cyc("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
